// File: rtl/depth_pixel_sink.sv
// depth_pixel_sink: pixel stream sink running a 3-stage depth test against a
// 1-cycle-latency depth RAM, committing passing pixels to depth and colour RAMs.
module depth_pixel_sink #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              begin_frame,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  logic [31:0]       in_depth,
  input  logic [11:0]       in_color,
  input  logic              in_compare_depth,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              depth_rd_en,
  output logic [ADDR_W-1:0] depth_rd_addr,
  input  logic [31:0]       depth_rd_data,
  output logic              depth_wr_en,
  output logic [ADDR_W-1:0] depth_wr_addr,
  output logic [31:0]       depth_wr_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [11:0]       fb_wr_data,
  output logic [31:0]       pass_count,
  output logic [31:0]       fail_count,
  output logic [31:0]       drop_count,
  output logic              busy
);
  logic              in_range, hazard, accept, load, pass;
  logic [ADDR_W-1:0] addr;
  logic              s1_v, s1_cmp, s2_v, s2_cmp, s3_v, s3_we;
  logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr;
  logic [31:0]       s1_depth, s2_depth, s3_depth;
  logic [11:0]       s1_color, s2_color, s3_color;

  assign in_range = in_pixel_x < 16'(WIDTH) && in_pixel_y < 16'(HEIGHT);
  assign addr     = ADDR_W'(in_pixel_y) * ADDR_W'(WIDTH) + ADDR_W'(in_pixel_x);
  // Stalling on any in-flight match keeps every read strictly after the prior write.
  assign hazard   = in_range && ((s1_v && s1_addr == addr) || (s2_v && s2_addr == addr) ||
                                 (s3_v && s3_addr == addr));
  assign in_ready = !rst && !hazard;
  assign accept   = in_valid && in_ready;
  assign load     = accept && in_range;
  assign pass     = !s2_cmp || $signed(s2_depth) < $signed(depth_rd_data);

  assign depth_rd_en   = s1_v && s1_cmp;
  assign depth_rd_addr = s1_addr;
  assign depth_wr_en   = s3_we;
  assign depth_wr_addr = s3_addr;
  assign depth_wr_data = s3_depth;
  assign fb_wr_en      = s3_we;
  assign fb_wr_addr    = s3_addr;
  assign fb_wr_data    = s3_color;
  assign busy          = s1_v || s2_v || s3_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_v, s1_cmp, s2_v, s2_cmp, s3_v, s3_we} <= '0;
      {s1_addr, s2_addr, s3_addr}               <= '0;
      {s1_depth, s2_depth, s3_depth}            <= '0;
      {s1_color, s2_color, s3_color}            <= '0;
      {pass_count, fail_count, drop_count}      <= '0;
    end else begin
      s1_v  <= load;
      s2_v  <= s1_v;
      s3_v  <= s2_v;
      s3_we <= s2_v && pass;
      if (load) {s1_cmp, s1_addr, s1_depth, s1_color} <= {in_compare_depth, addr, in_depth, in_color};
      if (s1_v) {s2_cmp, s2_addr, s2_depth, s2_color} <= {s1_cmp, s1_addr, s1_depth, s1_color};
      if (s2_v) {s3_addr, s3_depth, s3_color}         <= {s2_addr, s2_depth, s2_color};
      pass_count <= begin_frame ? '0 : pass_count + 32'(s2_v && pass && !(&pass_count));
      fail_count <= begin_frame ? '0 : fail_count + 32'(s2_v && !pass && !(&fail_count));
      drop_count <= begin_frame ? '0 : drop_count + 32'(accept && !in_range && !(&drop_count));
    end
  end
endmodule

// File: tb/tb_depth_pixel_sink.sv
// tb_depth_pixel_sink: directed and random pixel stream against a timed reference
// of the depth buffer, with a behavioural depth RAM attached.
module tb_depth_pixel_sink;
  localparam int W = 320, H = 240, AW = 17;
  logic          clk = 0, rst = 1, begin_frame = 0;
  logic [15:0]   in_pixel_x = 0, in_pixel_y = 0;
  logic [31:0]   in_depth = 0;
  logic [11:0]   in_color = 0;
  logic          in_compare_depth = 0, in_valid = 0, in_ready;
  logic          depth_rd_en, depth_wr_en, fb_wr_en, busy;
  logic [AW-1:0] depth_rd_addr, depth_wr_addr, fb_wr_addr;
  logic [31:0]   depth_rd_data = 0, depth_wr_data, pass_count, fail_count, drop_count;
  logic [11:0]   fb_wr_data;

  depth_pixel_sink #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .begin_frame(begin_frame),
    .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y), .in_depth(in_depth),
    .in_color(in_color), .in_compare_depth(in_compare_depth), .in_valid(in_valid),
    .in_ready(in_ready), .depth_rd_en(depth_rd_en), .depth_rd_addr(depth_rd_addr),
    .depth_rd_data(depth_rd_data), .depth_wr_en(depth_wr_en), .depth_wr_addr(depth_wr_addr),
    .depth_wr_data(depth_wr_data), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .pass_count(pass_count), .fail_count(fail_count),
    .drop_count(drop_count), .busy(busy));

  always #5 clk = ~clk;

  logic [31:0] mem   [0:W*H-1];
  logic [31:0] ref_d [0:W*H-1];
  always @(posedge clk) begin
    if (depth_wr_en) mem[depth_wr_addr] <= depth_wr_data;
    if (depth_rd_en) depth_rd_data <= mem[depth_rd_addr];
  end

  int cyc = 0;
  bit bf_q = 0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bf_q <= begin_frame;
  end

  // k = index of the edge at which the pixel was accepted
  typedef struct {
    int k; int addr; bit cmp; logic [31:0] stored; bit pass; logic [31:0] depth; logic [11:0] color;
  } pix_t;
  pix_t pq[$];
  int total = 0, bad = 0;
  logic [31:0] m_pass = 0, m_fail = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit stall(int a, bit inr, int n);
    foreach (pq[i]) if (inr && pq[i].k >= n - 2 && pq[i].addr == a) return 1;
    return 0;
  endfunction

  logic        exp_rd, chk_rd, exp_wr;
  logic [31:0] rd_a, rd_d, w_a, w_d;
  logic [11:0] w_c;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].k + 2 < cyc) void'(pq.pop_front());
    {exp_rd, chk_rd, exp_wr} = '0;
    {rd_a, rd_d, w_a, w_d, w_c} = '0;
    foreach (pq[i]) begin
      if (pq[i].k == cyc && pq[i].cmp) begin exp_rd = 1; rd_a = pq[i].addr; end
      if (pq[i].k + 1 == cyc && pq[i].cmp) begin chk_rd = 1; rd_d = pq[i].stored; end
      if (pq[i].k + 2 == cyc) begin
        if (pq[i].pass) begin
          exp_wr = 1; w_a = pq[i].addr; w_d = pq[i].depth; w_c = pq[i].color; m_pass++;
        end else m_fail++;
      end
    end
    if (bf_q) {m_pass, m_fail, m_drop} = '0;
    chk("rd_en", 32'(depth_rd_en), 32'(exp_rd));
    if (exp_rd) chk("rd_addr", 32'(depth_rd_addr), rd_a);
    if (chk_rd) chk("rd_data", depth_rd_data, rd_d);
    chk("fb_wr_en", 32'(fb_wr_en), 32'(exp_wr));
    chk("depth_wr_en", 32'(depth_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(depth_wr_addr), w_a);
      chk("fb_addr", 32'(fb_wr_addr), w_a);
      chk("wr_depth", depth_wr_data, w_d);
      chk("fb_color", 32'(fb_wr_data), 32'(w_c));
    end
    chk("busy", 32'(busy), 32'(pq.size() > 0));
    chk("pass_count", pass_count, m_pass);
    chk("fail_count", fail_count, m_fail);
    chk("drop_count", drop_count, m_drop);
  end

  task automatic model_accept(input int x, input int y, input logic [31:0] d,
                              input logic [11:0] c, input bit cmp, input int k);
    pix_t p;
    int a;
    if (x >= W || y >= H) begin m_drop++; return; end
    a = y * W + x;
    p.k = k; p.addr = a; p.cmp = cmp; p.stored = ref_d[a];
    p.pass = !cmp || $signed(d) < $signed(ref_d[a]);
    p.depth = d; p.color = c;
    if (p.pass) ref_d[a] = d;
    pq.push_back(p);
  endtask

  task automatic send(input int x, input int y, input logic [31:0] d, input logic [11:0] c,
                      input bit cmp, output int stalls);
    bit inr, r, acc;
    int n;
    inr = x < W && y < H;
    acc = 0;
    stalls = 0;
    in_pixel_x = 16'(x); in_pixel_y = 16'(y); in_depth = d; in_color = c;
    in_compare_depth = cmp; in_valid = 1;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      n = cyc;
      r = in_ready;
      chk("in_ready", 32'(r), 32'(!stall(y * W + x, inr, n)));
      @(posedge clk);
      #1;
      if (r) begin acc = 1; model_accept(x, y, d, c, cmp, n + 1); end
      else stalls++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_strobes"}, 32'({depth_rd_en, depth_wr_en, fb_wr_en, busy}), 0);
    chk({tag, "_addrs"}, 32'(depth_rd_addr | depth_wr_addr | fb_wr_addr), 0);
    chk({tag, "_data"}, depth_wr_data | 32'(fb_wr_data), 0);
    chk({tag, "_counts"}, pass_count | fail_count | drop_count, 0);
  endtask

  int s, s2;
  initial begin
    for (int i = 0; i < W * H; i++) begin mem[i] = 32'h7FFF_FFFF; ref_d[i] = 32'h7FFF_FFFF; end
    in_valid = 1;
    #3 check_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    // fill: unconditional writes, full rate
    send(0, 0, 32'h7FFF_FFFF, 12'hABC, 0, s);   chk("fill0_stall", s, 0);
    send(1, 0, 32'h7FFF_FFFF, 12'hABC, 0, s);   chk("fill1_stall", s, 0);
    send(319, 0, 32'h7FFF_FFFF, 12'hABC, 0, s); chk("fill2_stall", s, 0);
    send(0, 1, 32'h7FFF_FFFF, 12'hABC, 0, s);   chk("fill3_stall", s, 0);
    idle(4);
    chk("fill_pass", pass_count, 4);
    // depth test at address 5: nearer passes, equal fails, negative passes
    send(5, 0, 32'h0001_0000, 12'h111, 0, s);
    send(5, 0, 32'h0000_8000, 12'h222, 1, s); chk("same_addr_stall", s, 3);
    send(5, 0, 32'h0001_0000, 12'h333, 0, s);
    send(5, 0, 32'h0001_0000, 12'h444, 1, s);
    send(5, 0, 32'hFFFF_0000, 12'h555, 1, s);
    idle(4);
    chk("depth_pass", pass_count, 8);
    chk("depth_fail_equal", fail_count, 1);
    chk("neg_depth_stored", mem[5], 32'hFFFF_0000);
    // read-after-write hazard, then distinct addresses at full rate
    send(7, 2, 32'h0000_0100, 12'h0F0, 1, s);
    send(7, 2, 32'h0000_0080, 12'h00F, 1, s2); chk("hazard_stall", s2, 3);
    send(8, 2, 32'h0000_0100, 12'h0F1, 1, s);  chk("distinct_stall_a", s, 0);
    send(9, 2, 32'h0000_0100, 12'h0F2, 1, s);  chk("distinct_stall_b", s, 0);
    idle(4);
    chk("hazard_mem", mem[7 + 2 * W], 32'h80);
    // out-of-range pixels are consumed without touching the RAMs
    send(320, 0, 32'h1, 12'h1, 1, s); chk("drop_x_stall", s, 0);
    send(0, 240, 32'h1, 12'h1, 1, s); chk("drop_y_stall", s, 0);
    idle(3);
    chk("drop_count_2", drop_count, 2);
    // random stream over a small region to exercise hazards heavily
    begin_frame = 1; idle(1); begin_frame = 0;
    for (int i = 0; i < 300; i++) begin
      int x, y;
      x = $urandom_range(0, 8);
      y = $urandom_range(0, 2);
      if (x == 8) x = 320 + $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) y = 240;
      send(x, y, $urandom, 12'($urandom), $urandom_range(0, 3) != 0, s);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    chk("rand_total", pass_count + fail_count + drop_count, 300);
    // begin_frame coinciding with a pass increment wins
    send(20, 3, 32'h10, 12'h777, 0, s);
    idle(1);
    begin_frame = 1;
    @(posedge clk); #1;
    begin_frame = 0;
    chk("bf_same_cycle", pass_count, 0);
    idle(3);
    chk("bf_after", pass_count, 0);
    // reset with three pixels in flight
    send(30, 4, 32'h10, 12'h123, 0, s);
    send(31, 4, 32'h10, 12'h123, 0, s);
    send(32, 4, 32'h10, 12'h123, 1, s);
    in_valid = 0;
    rst = 1;
    #1;
    check_zero("midreset");
    pq.delete();
    {m_pass, m_fail, m_drop} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(6);
    chk("midreset_mem", mem[30 + 4 * W], 32'h7FFF_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
